// File: rtl/axi_digest_tx.sv
// AXI4-Stream digest transmitter: captures the low 512 bits of a finished Keccak state
// and streams the 224/256/384/512-bit digest selected by tid as DATA_WIDTH-bit beats.
module axi_digest_tx #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   start,
    input  logic [1:0]             tid_in,
    input  logic [4:0][4:0][63:0]  D_in,
    output logic                   ready,
    output logic                   M_TVALID,
    input  logic                   M_TREADY,
    output logic [DATA_WIDTH-1:0]  M_TDATA,
    output logic                   M_TLAST,
    output logic [1:0]             M_TID,
    output logic                   done
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state, next_state;
    logic [511:0]  shadow;
    logic [5:0]    idx;
    logic          tlast_q;
    logic [1:0]    tid_q;
    logic          done_q;
    logic [1599:0] flat;
    logic          unused_hi;
    logic          accept;
    logic          handshake;

    function automatic int digest_bits(input logic [1:0] tid);
        case (tid)
            2'd0:    digest_bits = 224;
            2'd1:    digest_bits = 256;
            2'd2:    digest_bits = 384;
            default: digest_bits = 512;
        endcase
    endfunction

    function automatic logic [6:0] beat_count(input logic [1:0] tid);
        beat_count = 7'((digest_bits(tid) + DATA_WIDTH - 1) / DATA_WIDTH);
    endfunction

    // Zeroing the tail at capture time means the shifted-out beats need no further masking.
    function automatic logic [511:0] digest_mask(input logic [1:0] tid);
        logic [511:0] m;
        for (int i = 0; i < 512; i++) begin
            m[i] = (i < digest_bits(tid));
        end
        digest_mask = m;
    endfunction

    assign flat      = D_in;
    assign unused_hi = ^flat[1599:512];

    assign accept    = (state == IDLE) && start;
    assign handshake = (state == SEND) && M_TREADY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        M_TVALID   = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                M_TVALID = 1'b1;
                if (M_TREADY && tlast_q) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Beat 0 sits in the low bits of the shadow; each accepted beat shifts the next one down.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            shadow  <= '0;
            idx     <= '0;
            tlast_q <= 1'b0;
            tid_q   <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= handshake && tlast_q;
            if (accept) begin
                shadow  <= flat[511:0] & digest_mask(tid_in);
                idx     <= '0;
                tid_q   <= tid_in;
                tlast_q <= (beat_count(tid_in) == 7'd1);
            end else if (handshake) begin
                shadow <= shadow >> DATA_WIDTH;
                if (tlast_q) begin
                    idx     <= '0;
                    tlast_q <= 1'b0;
                end else begin
                    idx     <= idx + 6'd1;
                    tlast_q <= ({1'b0, idx} + 7'd2 == beat_count(tid_q));
                end
            end
        end
    end

    assign M_TDATA = shadow[DATA_WIDTH-1:0];
    assign M_TLAST = tlast_q;
    assign M_TID   = tid_q;
    assign done    = done_q;

endmodule
